// File: rtl/approx_add_pipe.sv
// approx_add_pipe: pipelined lower-part-OR approximate adder with a
// run-time approximation depth and an on-chip accuracy monitor.
//
// For depth k the low k result bits are A|B, the carry into bit k is
// A[k-1]&B[k-1], and the upper bits are an exact add. k=0 is exact.
// A shadow exact adder gives |exact-approx| per beat. That value travels
// with the beat and feeds the statistics when the result is transferred.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake (in_a, in_b, in_k)
//   out_valid/out_ready     result handshake (out_sum, out_err)
//   stat_clr                synchronous clear of all statistics
//   stat_samples            results transferred (saturating)
//   stat_errors             transferred results with out_err=1 (saturating)
//   stat_max_err            largest |exact-approx| seen
//   stat_sum_err            sum of |exact-approx| (saturating)
module approx_add_pipe #(
  parameter int WIDTH      = 8,
  parameter int MAX_APPROX = 4,
  parameter int STAGES     = 2,
  parameter int CNT_W      = 32,
  parameter int ACC_W      = 40,
  localparam int KW        = (MAX_APPROX > 0) ? $clog2(MAX_APPROX + 1) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [KW-1:0]      in_k,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic               out_err,
  input  logic               stat_clr,
  output logic [CNT_W-1:0]   stat_samples,
  output logic [CNT_W-1:0]   stat_errors,
  output logic [WIDTH:0]     stat_max_err,
  output logic [ACC_W-1:0]   stat_sum_err
);

  localparam int SW   = WIDTH + 1;
  localparam int AW1  = ACC_W + 1;
  localparam int LAST = STAGES - 1;

  // Low k bits are OR-ed; the upper part is an exact add with the carry-in
  // guessed from bit k-1. Masking keeps the two halves disjoint, so the
  // final merge is a plain OR.
  function automatic logic [SW-1:0] approx_sum(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input int k);
    logic [WIDTH-1:0] lo_mask;
    logic [SW-1:0]    hi;
    logic             c;
    lo_mask = '0;
    c       = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i < k)     lo_mask[i] = 1'b1;
      if (i == k - 1) c = a[i] & b[i];
    end
    hi = {1'b0, a & ~lo_mask} + {1'b0, b & ~lo_mask} + (SW'(c) << k);
    return hi | {1'b0, (a | b) & lo_mask};
  endfunction

  // The approximation can over- or under-shoot, so order the operands
  // instead of relying on a signed subtract.
  function automatic logic [SW-1:0] abs_diff(input logic [SW-1:0] x,
                                             input logic [SW-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + CNT_W'(1);
  endfunction

  function automatic logic [ACC_W-1:0] sat_acc(input logic [ACC_W-1:0] acc,
                                               input logic [SW-1:0] e);
    logic [AW1-1:0] t;
    t = {1'b0, acc} + AW1'(e);
    return t[ACC_W] ? '1 : t[ACC_W-1:0];
  endfunction

  logic [KW-1:0] k_eff;
  logic [SW-1:0] sum_c;
  logic [SW-1:0] exact_c;
  logic [SW-1:0] err_c;

  always_comb begin
    k_eff   = (in_k > KW'(MAX_APPROX)) ? KW'(MAX_APPROX) : in_k;
    sum_c   = approx_sum(in_a, in_b, int'(k_eff));
    exact_c = {1'b0, in_a} + {1'b0, in_b};
    err_c   = abs_diff(exact_c, sum_c);
  end

  logic          vld_p   [STAGES];
  logic [SW-1:0] sum_p   [STAGES];
  logic [SW-1:0] err_p   [STAGES];
  logic          en      [STAGES];
  logic          src_vld [STAGES];
  logic [SW-1:0] src_sum [STAGES];
  logic [SW-1:0] src_err [STAGES];

  for (genvar g = 0; g < STAGES; g++) begin : g_src
    if (g == 0) begin : g_first
      assign src_vld[g] = in_valid;
      assign src_sum[g] = sum_c;
      assign src_err[g] = err_c;
    end else begin : g_next
      assign src_vld[g] = vld_p[g-1];
      assign src_sum[g] = sum_p[g-1];
      assign src_err[g] = err_p[g-1];
    end
  end

  // A stage loads when empty or when its contents move on this cycle; the
  // chain is evaluated from the output back so a full pipeline streams.
  always_comb begin
    logic rdy;
    en  = '{default: 1'b0};
    rdy = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      en[i] = !vld_p[i] || rdy;
      rdy   = en[i];
    end
  end

  assign in_ready = en[0];

  // ---- stage 0 captures the finished result; later stages only delay it ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < STAGES; i++) vld_p[i] <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (en[i]) vld_p[i] <= src_vld[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < STAGES; i++) begin
      if (en[i]) begin
        sum_p[i] <= src_sum[i];
        err_p[i] <= src_err[i];
      end
    end
  end

  // ---- output stage ----
  // Data registers carry no reset; qualifying with valid makes the outputs
  // read zero out of reset and while idle.
  assign out_valid = vld_p[LAST];
  assign out_sum   = vld_p[LAST] ? sum_p[LAST] : '0;
  assign out_err   = vld_p[LAST] && (err_p[LAST] != '0);

  logic xfer;
  assign xfer = vld_p[LAST] && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_samples <= '0;
      stat_errors  <= '0;
      stat_max_err <= '0;
      stat_sum_err <= '0;
    end else if (stat_clr) begin
      stat_samples <= '0;
      stat_errors  <= '0;
      stat_max_err <= '0;
      stat_sum_err <= '0;
    end else if (xfer) begin
      stat_samples <= sat_inc(stat_samples);
      if (out_err) stat_errors <= sat_inc(stat_errors);
      if (err_p[LAST] > stat_max_err) stat_max_err <= err_p[LAST];
      stat_sum_err <= sat_acc(stat_sum_err, err_p[LAST]);
    end
  end

endmodule

// File: tb/tb_approx_add_pipe.sv
// tb_approx_add_pipe: directed bench for approx_add_pipe (WIDTH=8,
// MAX_APPROX=4, STAGES=2, CNT_W=4). Expected results are queued at
// acceptance and compared in order against results collected on transfer.
module tb_approx_add_pipe;

  localparam int WIDTH      = 8;
  localparam int MAX_APPROX = 4;
  localparam int STAGES     = 2;
  localparam int CNT_W      = 4;
  localparam int ACC_W      = 40;
  localparam int KW         = 3;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_a;
  logic [WIDTH-1:0]   in_b;
  logic [KW-1:0]      in_k;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH:0]     out_sum;
  logic               out_err;
  logic               stat_clr;
  logic [CNT_W-1:0]   stat_samples;
  logic [CNT_W-1:0]   stat_errors;
  logic [WIDTH:0]     stat_max_err;
  logic [ACC_W-1:0]   stat_sum_err;

  always #5 clk = ~clk;

  approx_add_pipe #(
    .WIDTH(WIDTH), .MAX_APPROX(MAX_APPROX), .STAGES(STAGES),
    .CNT_W(CNT_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_k(in_k),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err),
    .stat_clr(stat_clr),
    .stat_samples(stat_samples), .stat_errors(stat_errors),
    .stat_max_err(stat_max_err), .stat_sum_err(stat_sum_err)
  );

  typedef struct {
    logic [WIDTH:0] sum;
    logic           err;
    logic [WIDTH:0] e;
  } exp_t;

  typedef struct {
    logic [WIDTH:0] sum;
    logic           err;
  } got_t;

  exp_t exp_q[$];
  got_t got_q[$];
  int   rd_idx   = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  // Collect every result that is about to transfer on the next rising edge.
  always @(negedge clk) begin
    got_t g;
    if (rst_n && out_valid && out_ready) begin
      g.sum = out_sum;
      g.err = out_err;
      got_q.push_back(g);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Bit-serial reference: OR below k, ripple carry from bit k upward.
  function automatic exp_t ref_add(input logic [7:0] a, input logic [7:0] b, input int k);
    int           kk;
    logic [8:0]   ex;
    logic [8:0]   s;
    logic         c;
    exp_t         r;
    kk = (k > MAX_APPROX) ? MAX_APPROX : k;
    ex = {1'b0, a} + {1'b0, b};
    s  = '0;
    c  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (i < kk) begin
        s[i] = a[i] | b[i];
      end else begin
        if (i == kk && kk > 0) c = a[kk-1] & b[kk-1];
        s[i] = a[i] ^ b[i] ^ c;
        c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
      end
    end
    s[8]  = c;
    r.sum = s;
    r.e   = (ex >= s) ? (ex - s) : (s - ex);
    r.err = (r.e != 0);
    return r;
  endfunction

  // Present one beat and wait (bounded) for it to be accepted.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] k,
                      input exp_t e);
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_k     = k;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      ok = in_ready;
      step();
    end
    if (ok) exp_q.push_back(e);
    chk("accept", ok, 1'b1);
  endtask

  task automatic send_m(input logic [7:0] a, input logic [7:0] b, input logic [2:0] k);
    send(a, b, k, ref_add(a, b, int'(k)));
  endtask

  task automatic compare_results();
    while (rd_idx < got_q.size() && rd_idx < exp_q.size()) begin
      chk($sformatf("sum[%0d]", rd_idx), got_q[rd_idx].sum, exp_q[rd_idx].sum);
      chk($sformatf("err[%0d]", rd_idx), got_q[rd_idx].err, exp_q[rd_idx].err);
      rd_idx++;
    end
  endtask

  task automatic drain();
    for (int t = 0; t < 60; t++) begin
      if (got_q.size() >= exp_q.size()) break;
      step();
    end
    repeat (2) step();
    chk("result_count", got_q.size(), exp_q.size());
    compare_results();
  endtask

  initial begin
    int   idx;
    int   base;
    logic acc;
    logic [WIDTH:0] held;
    int   e_cnt;
    int   e_sum;
    int   e_max;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_k      = '0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;

    // Reset state
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_err", out_err, 0);
    chk("rst_samples", stat_samples, 0);
    chk("rst_sum_err", stat_sum_err, 0);
    #10 rst_n = 1'b1;
    step();
    chk("rst_in_ready", in_ready, 1);

    // Exact mode and latency
    send(8'hFF, 8'h01, 3'd0, '{9'h100, 1'b0, 9'd0});
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      chk("lat_early", out_valid, 0);
      step();
    end
    chk("lat_valid", out_valid, 1);
    chk("lat_sum", out_sum, 9'h100);
    drain();

    // k=2 approximation and statistics
    send(8'h03, 8'h01, 3'd2, '{9'h003, 1'b1, 9'd1});
    in_valid = 1'b0;
    drain();
    chk("st_samples_2", stat_samples, 2);
    chk("st_errors_1", stat_errors, 1);
    chk("st_max_1", stat_max_err, 1);
    chk("st_sum_1", stat_sum_err, 1);

    // Overshoot error and clamping of in_k
    send(8'h07, 8'h07, 3'd3, '{9'h00F, 1'b1, 9'd1});
    send(8'h18, 8'h08, 3'd7, '{9'h028, 1'b1, 9'd8});
    send(8'hF0, 8'h30, 3'd7, '{9'h120, 1'b0, 9'd0});
    in_valid = 1'b0;
    drain();
    chk("st_errors_3", stat_errors, 3);
    chk("st_max_8", stat_max_err, 8);
    chk("st_sum_10", stat_sum_err, 10);

    // Backpressure: out_ready low for cycles 3..7 of an 8-beat stream
    idx  = 0;
    base = exp_q.size();
    held = '0;
    for (int cyc = 0; cyc < 60 && idx < 8; cyc++) begin
      out_ready = !(cyc >= 3 && cyc < 8);
      in_valid  = 1'b1;
      in_a      = 8'(idx * 37 + 5);
      in_b      = 8'(idx * 91 + 200);
      in_k      = 3'(idx % 6);
      @(negedge clk);
      if (cyc == 3) begin
        held = out_sum;
        chk("stall_sum", out_sum, exp_q[base + 1].sum);
      end
      if (cyc >= 3 && cyc < 8) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_hold", out_sum, held);
      end
      if (cyc == 7) chk("stall_in_ready", in_ready, 0);
      acc = in_ready;
      step();
      if (acc) begin
        exp_q.push_back(ref_add(in_a, in_b, int'(in_k)));
        idx++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // stat_clr in the same cycle as a transfer
    send_m(8'h55, 8'h2A, 3'd1);
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) step();
    chk("clr_out_valid", out_valid, 1);
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_samples", stat_samples, 0);
    chk("clr_errors", stat_errors, 0);
    chk("clr_max", stat_max_err, 0);
    chk("clr_sum", stat_sum_err, 0);
    drain();

    // Long run: counters saturate
    base = exp_q.size();
    for (int i = 0; i < 20; i++)
      send_m(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
             3'($urandom_range(0, 7)));
    in_valid = 1'b0;
    drain();
    e_cnt = 0;
    e_sum = 0;
    e_max = 0;
    for (int i = base; i < exp_q.size(); i++) begin
      e_cnt += int'(exp_q[i].err);
      e_sum += int'(exp_q[i].e);
      if (int'(exp_q[i].e) > e_max) e_max = int'(exp_q[i].e);
    end
    if (e_cnt > 15) e_cnt = 15;
    chk("sat_samples", stat_samples, 15);
    chk("sat_errors", stat_errors, e_cnt);
    chk("sat_max", stat_max_err, e_max);
    chk("sat_sum", stat_sum_err, e_sum);

    // Asynchronous reset in the middle of a stream
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1;
      in_a     = 8'(cyc * 29 + 3);
      in_b     = 8'(cyc * 53 + 11);
      in_k     = 3'(cyc % 5);
      @(negedge clk);
      acc = in_ready;
      step();
      if (acc) exp_q.push_back(ref_add(in_a, in_b, int'(in_k)));
    end
    #2 rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_sum", out_sum, 0);
    chk("arst_samples", stat_samples, 0);
    chk("arst_errors", stat_errors, 0);
    chk("arst_max", stat_max_err, 0);
    chk("arst_sum", stat_sum_err, 0);
    compare_results();
    while (exp_q.size() > got_q.size()) void'(exp_q.pop_back());
    step();
    step();
    #3 rst_n = 1'b1;
    step();
    chk("arst_in_ready", in_ready, 1);
    chk("arst_idle", out_valid, 0);
    send(8'hFF, 8'h01, 3'd0, '{9'h100, 1'b0, 9'd0});
    in_valid = 1'b0;
    for (int i = 1; i < STAGES; i++) begin
      chk("arst_lat_early", out_valid, 0);
      step();
    end
    chk("arst_lat_valid", out_valid, 1);
    drain();
    chk("arst_samples_1", stat_samples, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
